vga_pixel_out: RTL and testbench

// Final video stage, directly downstream of the object priority mux. Generates 640x480@60 VGA timing
//  and drives pixelX/pixelY to all drawers. Takes the mux's registered RGB332 pixel, delays sync/blank
//  to match the drawer+mux pipeline, expands to 8:8:8, and applies a frame-stepped fade-out/hold/fade-in.

---
 rtl/vga_timing_pkg.sv | 64 ++++++
 rtl/vga_pixel_out_sync_counter.sv | 60 ++++++
 rtl/vga_pixel_out.sv | 164 ++++++++++++++++
 tb/tb_vga_pixel_out.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480@60 timing constants, fade FSM type and colour helpers
package vga_timing_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int H_FP        = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BP        = 48;
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HS_START    = H_ACTIVE + H_FP;
    localparam int HS_END      = HS_START + H_SYNC;

    localparam int V_ACTIVE    = 480;
    localparam int V_FP        = 10;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 33;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VS_START    = V_ACTIVE + V_FP;
    localparam int VS_END      = VS_START + V_SYNC;

    localparam int PIPE_DLY    = 2;
    localparam int HOLD_FRAMES = 30;
    localparam int FADE_MAX    = 8;
    localparam int LEVEL_W     = 4;
    localparam int COORD_W     = 11;

    typedef enum logic [1:0] {
        FADE_IDLE,
        FADE_OUT,
        FADE_HOLD,
        FADE_IN
    } fade_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
    } video_ctl_t;

    localparam video_ctl_t CTL_INACTIVE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    // Bit replication keeps full-scale codes at 0xFF and zero at 0x00.
    function automatic rgb888_t expand_rgb332(input logic [7:0] c);
        rgb888_t x;
        x.r = {c[7:5], c[7:5], c[7:6]};
        x.g = {c[4:2], c[4:2], c[4:3]};
        x.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
        return x;
    endfunction

    function automatic logic [7:0] fade_scale(input logic [7:0] c, input logic [LEVEL_W-1:0] level);
        logic [10:0] prod;
        logic [3:0]  gain;
        gain = 4'(FADE_MAX) - level;
        prod = 11'(c) * 11'(gain);
        return prod[10:3];
    endfunction

endpackage

// File: rtl/vga_pixel_out_sync_counter.sv
// rtl/vga_pixel_out_sync_counter.sv - horizontal/vertical counters and raw sync/active timing
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC_W = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SYNC_W = V_SYNC,
    parameter int V_BACK   = V_BP
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] pixel_x_o,
    output logic [COORD_W-1:0] pixel_y_o,
    output logic               sof_o,
    output logic               active_o,
    output logic               hs_n_o,
    output logic               vs_n_o
);

    localparam int HT  = H_ACT + H_FRONT + H_SYNC_W + H_BACK;
    localparam int VT  = V_ACT + V_FRONT + V_SYNC_W + V_BACK;
    localparam int HSS = H_ACT + H_FRONT;
    localparam int HSE = HSS + H_SYNC_W;
    localparam int VSS = V_ACT + V_FRONT;
    localparam int VSE = VSS + V_SYNC_W;

    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + COORD_W'(1);
        v_d = v_q;
        if (h_q == COORD_W'(HT - 1)) begin
            h_d = '0;
            v_d = (v_q == COORD_W'(VT - 1)) ? '0 : v_q + COORD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign pixel_x_o = h_q;
    assign pixel_y_o = v_q;
    assign sof_o     = (h_q == '0) && (v_q == '0);
    assign active_o  = (h_q < COORD_W'(H_ACT)) && (v_q < COORD_W'(V_ACT));
    assign hs_n_o    = !((h_q >= COORD_W'(HSS)) && (h_q < COORD_W'(HSE)));
    assign vs_n_o    = !((v_q >= COORD_W'(VSS)) && (v_q < COORD_W'(VSE)));

endmodule

// File: rtl/vga_pixel_out.sv
// rtl/vga_pixel_out.sv - VGA output stage: sync alignment, RGB332 expansion and frame-stepped fade
module vga_pixel_out
    import vga_timing_pkg::*;
#(
    parameter int H_ACT       = H_ACTIVE,
    parameter int H_FRONT     = H_FP,
    parameter int H_SYNC_W    = H_SYNC,
    parameter int H_BACK      = H_BP,
    parameter int V_ACT       = V_ACTIVE,
    parameter int V_FRONT     = V_FP,
    parameter int V_SYNC_W    = V_SYNC,
    parameter int V_BACK      = V_BP,
    parameter int PIPE_STAGES = PIPE_DLY,
    parameter int HOLD_N      = HOLD_FRAMES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RGBIn,
    input  logic        fade_req,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        h_sync,
    output logic        v_sync,
    output logic        blank_n,
    output logic        fade_busy,
    output logic        fade_black
);

    localparam int HOLD_W = $clog2(HOLD_N + 1);

    logic       sof;
    logic       active_raw;
    logic       hs_raw_n;
    logic       vs_raw_n;

    vga_sync_counter #(
        .H_ACT    (H_ACT),
        .H_FRONT  (H_FRONT),
        .H_SYNC_W (H_SYNC_W),
        .H_BACK   (H_BACK),
        .V_ACT    (V_ACT),
        .V_FRONT  (V_FRONT),
        .V_SYNC_W (V_SYNC_W),
        .V_BACK   (V_BACK)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .pixel_x_o (pixelX),
        .pixel_y_o (pixelY),
        .sof_o     (sof),
        .active_o  (active_raw),
        .hs_n_o    (hs_raw_n),
        .vs_n_o    (vs_raw_n)
    );

    assign startOfFrame = sof;

    // Timing rides alongside the drawer+mux pipeline so it meets RGBIn for the same pixel.
    video_ctl_t pipe_q [PIPE_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe_q[i] <= CTL_INACTIVE;
            end
        end else begin
            pipe_q[0] <= '{active: active_raw, hs_n: hs_raw_n, vs_n: vs_raw_n};
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    fade_state_t        state_q;
    logic [LEVEL_W-1:0] level_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               black_q;

    // Level only moves on startOfFrame, which falls in blanking, so no frame is split.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FADE_IDLE;
            level_q <= '0;
            hold_q  <= '0;
            black_q <= 1'b0;
        end else begin
            black_q <= 1'b0;
            case (state_q)
                FADE_IDLE: begin
                    if (fade_req) begin
                        state_q <= FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    if (sof) begin
                        level_q <= level_q + LEVEL_W'(1);
                        if (level_q == LEVEL_W'(FADE_MAX - 1)) begin
                            state_q <= FADE_HOLD;
                            hold_q  <= HOLD_W'(HOLD_N);
                            black_q <= 1'b1;
                        end
                    end
                end
                FADE_HOLD: begin
                    if (sof) begin
                        hold_q <= hold_q - HOLD_W'(1);
                        if (hold_q == HOLD_W'(1)) begin
                            state_q <= FADE_IN;
                        end
                    end
                end
                FADE_IN: begin
                    if (sof) begin
                        level_q <= level_q - LEVEL_W'(1);
                        if (level_q == LEVEL_W'(1)) begin
                            state_q <= FADE_IDLE;
                        end
                    end
                end
                default: state_q <= FADE_IDLE;
            endcase
        end
    end

    assign fade_busy  = (state_q != FADE_IDLE);
    assign fade_black = black_q;

    rgb888_t    exp_c;
    rgb888_t    colour_d, colour_q;
    video_ctl_t ctl_d, ctl_q;

    always_comb begin
        exp_c    = expand_rgb332(RGBIn);
        ctl_d    = pipe_q[PIPE_STAGES-1];
        colour_d = '0;
        if (ctl_d.active) begin
            colour_d.r = fade_scale(exp_c.r, level_q);
            colour_d.g = fade_scale(exp_c.g, level_q);
            colour_d.b = fade_scale(exp_c.b, level_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colour_q <= '0;
            ctl_q    <= CTL_INACTIVE;
        end else begin
            colour_q <= colour_d;
            ctl_q    <= ctl_d;
        end
    end

    assign red     = colour_q.r;
    assign green   = colour_q.g;
    assign blue    = colour_q.b;
    assign h_sync  = ctl_q.hs_n;
    assign v_sync  = ctl_q.vs_n;
    assign blank_n = ctl_q.active;

endmodule

// File: tb/tb_vga_pixel_out.sv
// tb/tb_vga_pixel_out.sv - self-checking bench for vga_pixel_out with reduced raster timing
module tb_vga_pixel_out;

    localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
    localparam int VA = 6, VFP = 1, VSW = 2, VBP = 2;
    localparam int PD = 2, HOLD = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam int FADE_FRAMES = 16 + HOLD;
    localparam logic [7:0] RAMP [0:18] = '{8'hFF, 8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00,
                                           8'h00, 8'h00, 8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F, 8'hBF, 8'hDF, 8'hFF};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  RGBIn = 8'h00;
    logic        fade_req = 1'b0;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame;
    logic [7:0]  red, green, blue;
    logic        h_sync, v_sync, blank_n, fade_busy, fade_black;

    vga_pixel_out #(
        .H_ACT(HA), .H_FRONT(HFP), .H_SYNC_W(HSW), .H_BACK(HBP),
        .V_ACT(VA), .V_FRONT(VFP), .V_SYNC_W(VSW), .V_BACK(VBP),
        .PIPE_STAGES(PD), .HOLD_N(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .RGBIn(RGBIn), .fade_req(fade_req),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .red(red), .green(green), .blue(blue),
        .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n),
        .fade_busy(fade_busy), .fade_black(fade_black)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int req_frame = -1;
    int req_cycle = 0;
    bit solid = 1'b0;
    logic [7:0] rgb_hist [0:32767];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int lvl_of(input int frame);
        int d;
        if (req_frame < 0) return 0;
        d = frame - req_frame;
        if (d <= 0) return 0;
        if (d <= 8) return d;
        if (d <= 8 + HOLD) return 8;
        if (d < FADE_FRAMES) return FADE_FRAMES - d;
        return 0;
    endfunction

    function automatic bit busy_at(input int c);
        return (req_frame >= 0) && (c > req_cycle) && (c <= (req_frame + FADE_FRAMES) * FT);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            cyc = 0;
            req_frame = -1;
        end else begin
            if (cyc < 32768) rgb_hist[cyc] = RGBIn;
            if (fade_req && !busy_at(cyc)) begin
                req_frame = cyc / FT;
                req_cycle = cyc;
            end
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        int n, h, v, c, lv, r3, g3, b2;
        int er, eg, eb, ehs, evs, eact;
        if (reset) begin
            chk("rst_pixelX", int'(pixelX), 0);
            chk("rst_sof", int'(startOfFrame), 1);
            chk("rst_colour", int'({red, green, blue}), 0);
            chk("rst_sync", int'({h_sync, v_sync, blank_n}), 3'b110);
            chk("rst_fade", int'({fade_busy, fade_black}), 0);
        end else begin
            chk("pixelX", int'(pixelX), cyc % HT);
            chk("pixelY", int'(pixelY), (cyc / HT) % VT);
            chk("sof", int'(startOfFrame), int'(cyc % FT == 0));
            n = cyc - PD - 1;
            er = 0; eg = 0; eb = 0; ehs = 1; evs = 1; eact = 0;
            if (n >= 0) begin
                h = n % HT;
                v = (n / HT) % VT;
                eact = int'(h < HA && v < VA);
                ehs = int'(!(h >= HA + HFP && h < HA + HFP + HSW));
                evs = int'(!(v >= VA + VFP && v < VA + VFP + VSW));
                if (eact != 0) begin
                    c = int'(rgb_hist[cyc - 1]);
                    r3 = (c >> 5) & 7;
                    g3 = (c >> 2) & 7;
                    b2 = c & 3;
                    lv = lvl_of(n / FT);
                    er = ((r3 * 255 + 3) / 7) * (8 - lv) / 8;
                    eg = ((g3 * 255 + 3) / 7) * (8 - lv) / 8;
                    eb = (b2 * 85) * (8 - lv) / 8;
                end
            end
            chk("red", int'(red), er);
            chk("green", int'(green), eg);
            chk("blue", int'(blue), eb);
            chk("h_sync", int'(h_sync), ehs);
            chk("v_sync", int'(v_sync), evs);
            chk("blank_n", int'(blank_n), eact);
            chk("fade_busy", int'(fade_busy), int'(busy_at(cyc)));
            chk("fade_black", int'(fade_black), int'(req_frame >= 0 && cyc == (req_frame + 8) * FT + 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        fade_req = 1'b0;
        RGBIn = solid ? 8'hFF : 8'($urandom);
    endtask

    task automatic wait_px(input int x, input int y);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            tick();
            found = (int'(pixelX) == x) && (int'(pixelY) == y);
        end
        if (!found) chk("wait_px_timeout", 0, 1);
    endtask

    task automatic wait_sof();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            tick();
            found = startOfFrame;
        end
        if (!found) chk("wait_sof_timeout", 0, 1);
    endtask

    initial begin
        int t0, hs_low, first_low_x, line0, rf, rc, fall, nblack;
        bit prev_hs, done;

        #1 reset = 1'b1;
        repeat (5) tick();
        chk("lit_rst_red", int'(red), 0);
        chk("lit_rst_hsync", int'(h_sync), 1);
        chk("lit_rst_blank", int'(blank_n), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lit_px_count", int'(pixelX), i);
            tick();
        end

        wait_sof();
        t0 = cyc;
        hs_low = 0; first_low_x = -1; prev_hs = 1'b1; line0 = -1;
        for (int i = 0; i < FT; i++) begin
            tick();
            if (!h_sync) hs_low++;
            if (!h_sync && prev_hs && first_low_x < 0) first_low_x = int'(pixelX);
            prev_hs = h_sync;
            if (pixelX == 0 && pixelY == 1 && line0 < 0) line0 = cyc - t0;
        end
        chk("lit_frame_len", cyc - t0, 275);
        chk("lit_line_len", line0, 25);
        chk("lit_hs_low_cycles", hs_low, 44);
        chk("lit_hs_first_x", first_low_x, 21);

        wait_px(12, 3);
        RGBIn = 8'hE0;
        tick();
        chk("lit_e0_red", int'(red), 8'hFF);
        chk("lit_e0_green", int'(green), 0);
        chk("lit_e0_blue", int'(blue), 0);
        chk("lit_e0_blank", int'(blank_n), 1);

        wait_px(22, 3);
        RGBIn = 8'hFF;
        tick();
        chk("lit_blank_red", int'(red), 0);
        chk("lit_blank_bn", int'(blank_n), 0);

        solid = 1'b1;
        wait_px(5, 2);
        fade_req = 1'b1;
        rf = cyc / FT; rc = cyc;
        fall = -1; nblack = 0; done = 1'b0;
        for (int i = 0; i < 20 * FT && !done; i++) begin
            int d;
            tick();
            d = cyc / FT - rf;
            if (fade_black) nblack++;
            if (d == 4 && cyc % FT == 100) fade_req = 1'b1;
            if (cyc % FT == PD + 1 && d >= 1 && d <= 18) chk("lit_ramp_red", int'(red), int'(RAMP[d]));
            if (fall < 0 && !fade_busy && cyc > rc + 1) fall = cyc;
            done = (fall >= 0) && (cyc >= fall + PD + 2);
        end
        if (!done) chk("fade_timeout", 0, 1);
        chk("lit_fade_frames", (fall - 1) / FT - rf, 18);
        chk("lit_black_pulses", nblack, 1);

        solid = 1'b0;
        wait_sof();
        fade_req = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 * FT && !done; i++) begin
            tick();
            done = fade_black;
        end
        if (!done) chk("black_timeout", 0, 1);
        repeat (FT / 2) tick();
        chk("lit_hold_busy", int'(fade_busy), 1);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("lit_post_rst_busy", int'(fade_busy), 0);
        solid = 1'b1;
        while (cyc < FT + PD + 1) tick();
        chk("lit_post_rst_red", int'(red), 8'hFF);

        solid = 1'b0;
        for (int i = 0; i < 25 * FT; i++) begin
            tick();
            if ($urandom_range(0, 299) == 0) fade_req = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
